controller_sequencer: RTL
=========================

# controller_sequencer

Control unit for the 8-bit CPU. Runs a six-state one-hot T-state ring (T1–T6) and decodes the instruction-register opcode into the per-cycle control word. The control word drives every load/enable strobe on the shared 8-bit bus. This block sits directly upstream of the program counter and drives its `cp`, `ep` and `lp` inputs. It also sequences the MAR, RAM, IR, A, B, ALU and output register.

## Interface
- No parameters; opcode map and state count are fixed.
- `clk  in  1` — system clock, rising-edge active.
- `clr  in  1` — reset; one clock; reset is asynchronous and active-high.
- `opcode  in  4` — IR upper nibble; valid from T4 onward.
- `cp  out  1` — PC count enable.
- `ep  out  1` — PC drives bus.
- `lp  out  1` — PC loads from bus.
- `lm  out  1` — MAR load.
- `ce  out  1` — RAM drives bus.
- `li  out  1` — IR load.
- `ei  out  1` — IR operand nibble drives bus.
- `la  out  1` — A load.
- `ea  out  1` — A drives bus.
- `lb  out  1` — B load.
- `su  out  1` — ALU subtract select.
- `eu  out  1` — ALU drives bus.
- `lo  out  1` — output register load.
- `tstate  out  6` — one-hot state: bit0 = T1 … bit5 = T6; 000000 = halted.
- `halted  out  1` — high while stopped by HLT.

## Operation
- All strobes are active-high and combinational from the registered `tstate` and `opcode`. Downstream registers act on the next rising edge.
- **Ring:** T1→T2→…→T6→T1, one state per clock. There is no early termination; every instruction takes 6 cycles.
- **Fetch (opcode ignored):**
  - T1: `ep`, `lm`.
  - T2: `cp`.
  - T3: `ce`, `li`.
- **Execute (T4 / T5 / T6):**
  - LDA 0000: `ei lm` / `ce la` / none.
  - ADD 0001: `ei lm` / `ce lb` / `eu la`.
  - SUB 0010: `ei lm` / `ce lb` / `eu la su`.
  - JMP 0011: `ei lp` / none / none.
  - OUT 1110: `ea lo` / none / none.
  - HLT 1111: none in T4; on the T4 edge, `tstate`←000000 and `halted`←1.
  - Any other opcode is a NOP: no strobes in T4–T6.
- **Halted state:**
  - All strobes are 0 and `tstate` holds 000000.
  - `clk` edges have no effect. Only `clr` exits.
- **Bus rule:** at most one of `ep ce ei ea eu` is high in any state, for every opcode.
- `cp` and `lp` are never high together.
- An illegal `tstate` (not one-hot and not 000000) recovers to T1 on the next edge.

## Timing
- **Reset:**
  - While `clr`=1: `tstate`=000001 (T1) and `halted`=0.
  - Strobes reflect T1: `ep`=1, `lm`=1, all others 0.
  - Assertion takes effect immediately, independent of `clk`.
- **After release:** the first rising edge moves T1→T2.
- **`clr` mid-instruction:** the ring returns to T1 asynchronously. Partially executed strobes drop in the same instant; no state is retained.
- **`clr` while halted:** `halted` clears and T1 resumes.
- **PC interaction:**
  - `cp` high in T2 increments the PC on the T2→T3 edge.
  - `lp` high in T4 loads the PC on the T4→T5 edge.
  - A JMP therefore takes effect at the next T1.
- **Opcode timing:** the IR loads on the T3→T4 edge. Changes to `opcode` during T1–T3 must not affect any output.
- **Throughput:** one instruction per 6 clocks. Halt latency is 4 clocks after the HLT fetch begins.

## Test plan
- **Reset:** assert `clr` mid-T5 of an ADD → same-instant `tstate`=000001, `ep`=`lm`=1, all other strobes 0. Release, clock 1 → `tstate`=000010, `cp`=1.
- **Fetch/ADD:** `opcode`=0001, clock 6 cycles → strobe sequence {ep,lm},{cp},{ce,li},{ei,lm},{ce,lb},{eu,la}, then back to T1.
- **SUB vs LDA:**
  - `opcode`=0010 → `su`=1 only in T6.
  - `opcode`=0000 → T6 has all strobes 0.
- **JMP:** `opcode`=0011 → `ei`=`lp`=1 in T4 only, `cp`=0 there. Across all opcodes and states, never `cp`&`lp`, and bus enables are one-hot-or-zero (assert every cycle).
- **OUT/NOP:**
  - `opcode`=1110 → `ea`=`lo`=1 in T4.
  - `opcode`=0101 → all strobes 0 in T4–T6.
  - Toggling `opcode` during T1–T3 leaves outputs unchanged.
- **HLT:** `opcode`=1111 → after the T4 edge, `tstate`=000000, `halted`=1, strobes 0. The state holds for 20 clocks. Pulsing `clr` → T1, `halted`=0.

Source files
------------

// File: rtl/controller_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | controller_sequencer                                                     |
// | Six-state one-hot T-state ring and opcode decoder for the 8-bit CPU.     |
// | Rev 1.0 - initial release                                                |
// +--------------------------------------------------------------------------+
module controller_sequencer (
  input  logic       clk,
  input  logic       clr,
  input  logic [3:0] opcode,
  output logic       cp,
  output logic       ep,
  output logic       lp,
  output logic       lm,
  output logic       ce,
  output logic       li,
  output logic       ei,
  output logic       la,
  output logic       ea,
  output logic       lb,
  output logic       su,
  output logic       eu,
  output logic       lo,
  output logic [5:0] tstate,
  output logic       halted
);

  localparam logic [3:0] C_OP_LDA = 4'b0000;
  localparam logic [3:0] C_OP_ADD = 4'b0001;
  localparam logic [3:0] C_OP_SUB = 4'b0010;
  localparam logic [3:0] C_OP_JMP = 4'b0011;
  localparam logic [3:0] C_OP_OUT = 4'b1110;
  localparam logic [3:0] C_OP_HLT = 4'b1111;

  typedef enum logic [5:0] {
    S_HALT = 6'b000000,
    S_T1   = 6'b000001,
    S_T2   = 6'b000010,
    S_T3   = 6'b000100,
    S_T4   = 6'b001000,
    S_T5   = 6'b010000,
    S_T6   = 6'b100000
  } state_t;

  state_t r_state;
  state_t w_next;

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      r_state <= S_T1;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = S_T1;
    cp = 1'b0;
    ep = 1'b0;
    lp = 1'b0;
    lm = 1'b0;
    ce = 1'b0;
    li = 1'b0;
    ei = 1'b0;
    la = 1'b0;
    ea = 1'b0;
    lb = 1'b0;
    su = 1'b0;
    eu = 1'b0;
    lo = 1'b0;
    case (r_state)
      S_HALT: w_next = S_HALT;
      S_T1: begin
        w_next = S_T2;
        ep     = 1'b1;
        lm     = 1'b1;
      end
      S_T2: begin
        w_next = S_T3;
        cp     = 1'b1;
      end
      S_T3: begin
        w_next = S_T4;
        ce     = 1'b1;
        li     = 1'b1;
      end
      S_T4: begin
        w_next = (opcode == C_OP_HLT) ? S_HALT : S_T5;
        case (opcode)
          C_OP_LDA, C_OP_ADD, C_OP_SUB: begin
            ei = 1'b1;
            lm = 1'b1;
          end
          C_OP_JMP: begin
            ei = 1'b1;
            lp = 1'b1;
          end
          C_OP_OUT: begin
            ea = 1'b1;
            lo = 1'b1;
          end
          default: ;
        endcase
      end
      S_T5: begin
        w_next = S_T6;
        case (opcode)
          C_OP_LDA: begin
            ce = 1'b1;
            la = 1'b1;
          end
          C_OP_ADD, C_OP_SUB: begin
            ce = 1'b1;
            lb = 1'b1;
          end
          default: ;
        endcase
      end
      S_T6: begin
        w_next = S_T1;
        if (opcode == C_OP_ADD || opcode == C_OP_SUB) begin
          eu = 1'b1;
          la = 1'b1;
          su = (opcode == C_OP_SUB);
        end
      end
      // Any non-one-hot encoding falls back into the fetch cycle.
      default: w_next = S_T1;
    endcase
  end

  assign tstate = r_state;
  assign halted = (r_state == S_HALT);

endmodule
`default_nettype wire
